multicore_debug_sequencer: RTL and testbench
============================================

Name: multicore_debug_sequencer

Overview:
- Host-side controller that sequences debug accesses to the per-core Nios II debug monitors of the 8-core system.
- Accepts one command at a time: single-core OCI memory read/write, broadcast halt-all, or broadcast resume-all.
- Drives per-core request/break/resume strobes, waits for monitor_ready or debugack with a timeout, and returns one response per command.
- Sits between the system-level debug host bridge and the NUM_CORES per-core debug monitor interfaces.

Parameters:
- NUM_CORES, 8, number of cores served (1..8).
- CORE_ID_W, 3, width of the core index field.
- TIMEOUT_CYCLES, 1023, maximum wait cycles before timeout (>=2); counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 read, 01 write, 10 halt_all, 11 resume_all.
- cmd_core  in  CORE_ID_W  target core (read/write only).
- cmd_addr  in  8  OCI memory word address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data, or debugack vector (zero-extended) for broadcast ops.
- rsp_status  out  2  00 ok, 01 monitor_error, 10 timeout, 11 bad_core.
- core_req  out  NUM_CORES  one-hot, 1-cycle access strobe.
- core_we  out  1  write qualifier.
- core_addr  out  8  access address.
- core_wdata  out  32  access write data.
- core_rdata  in  NUM_CORES*32  per-core MonDReg; core i is at bits [32i+31:32i].
- core_ready  in  NUM_CORES  per-core monitor_ready.
- core_error  in  NUM_CORES  per-core monitor_error.
- core_break_req  out  NUM_CORES  level break request.
- core_resume_req  out  NUM_CORES  level resume request.
- core_debugack  in  NUM_CORES  per-core debugack.

Behaviour:
- States: IDLE, ISSUE, WAIT, HALT_WAIT, RESUME_WAIT, RESP.
- Reset:
  - State goes to IDLE; wait counter is 0.
  - All outputs are 0 (cmd_ready is 0 during reset, then 1 the cycle after reset deasserts).
  - Reset mid-operation drops all core strobes and any pending response; no response is emitted.
- IDLE:
  - cmd_ready=1; all other outputs 0 except held rsp_rdata/rsp_status (don't-care).
  - On accept, cmd fields are latched and cmd_ready drops the next cycle.
  - Transitions on accept:
    - read/write with cmd_core >= NUM_CORES: go to RESP with status 11, rdata 0.
    - read/write with a valid core: go to ISSUE.
    - halt_all: go to HALT_WAIT.
    - resume_all: go to RESUME_WAIT.
- ISSUE (exactly 1 cycle):
  - core_req[core]=1.
  - core_we/core_addr/core_wdata driven from latched values; held stable through WAIT.
  - core_ready is ignored in ISSUE.
  - Go to WAIT; counter cleared to 0.
- WAIT:
  - Sample core_ready[core] each cycle.
  - If high: rdata = core_rdata slice (read) or 0 (write); status = core_error[core] ? 01 : 00; go to RESP.
  - Otherwise the counter increments.
  - After TIMEOUT_CYCLES WAIT cycles without ready: status 10, rdata 0, go to RESP.
  - If ready and timeout occur in the same cycle, ready wins.
- HALT_WAIT:
  - core_break_req = all ones (NUM_CORES bits).
  - Exit when core_debugack is all ones: status 00.
  - Or exit on timeout after TIMEOUT_CYCLES cycles: status 10.
  - On exit, rdata = debugack vector sampled that cycle; core_break_req deasserts in RESP.
- RESUME_WAIT:
  - Same as HALT_WAIT but with core_resume_req all ones.
  - Completion condition is core_debugack all zeros.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_status held stable until rsp_ready.
  - On handshake, go to IDLE; the next command can be accepted 1 cycle later (no back-to-back overlap).
- Latency:
  - Accept in cycle T; ISSUE in T+1; first WAIT cycle T+2.
  - Ready in T+2 gives rsp_valid in T+3.
  - Bad core: rsp_valid in T+1.
- Only one command is outstanding; core_req never has more than one bit set.
- Broadcast ops ignore cmd_core.

Test Plan:
- Read core 5, addr 0x12; core_ready[5] high 4 cycles into WAIT with rdata 0xDEADBEEF -> exactly one core_req=0x20 pulse; rsp_rdata=0xDEADBEEF, status 00.
- Write core 0, wdata 0x0000A5A5; core_ready[0] high on the first WAIT cycle -> core_we=1, core_wdata=0x0000A5A5, addr held; rsp_valid in T+3; status 00, rdata 0.
- TIMEOUT_CYCLES=16, read core 2 with core_ready never asserted -> rsp_valid after 16 WAIT cycles; status 10, rdata 0. Also: ready on the 16th cycle -> status 00.
- NUM_CORES=6, read with cmd_core=7 -> no core_req; rsp_valid in T+1 with status 11.
- halt_all: debugack bits assert staggered, last at cycle 9 -> break_req=0xFF until then; status 00, rdata=0x000000FF. Then resume_all with debugack stuck at 0x08 -> status 10, rdata=0x00000008.
- rsp_ready held low 5 cycles, then reset asserted in WAIT and during RESP -> response stays stable while stalled; after reset all outputs 0, no response, cmd_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/multicore_debug_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : multicore_debug_sequencer_if
// Purpose  : Host command/response channel plus per-core debug monitor
//            signals for the multicore debug sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface multicore_debug_sequencer_if #(
    parameter int NUM_CORES = 8,
    parameter int CORE_ID_W = 3
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [CORE_ID_W-1:0]      cmd_core;
    logic [7:0]                cmd_addr;
    logic [31:0]               cmd_wdata;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [31:0]               rsp_rdata;
    logic [1:0]                rsp_status;

    logic [NUM_CORES-1:0]      core_req;
    logic                      core_we;
    logic [7:0]                core_addr;
    logic [31:0]               core_wdata;
    logic [NUM_CORES*32-1:0]   core_rdata;
    logic [NUM_CORES-1:0]      core_ready;
    logic [NUM_CORES-1:0]      core_error;
    logic [NUM_CORES-1:0]      core_break_req;
    logic [NUM_CORES-1:0]      core_resume_req;
    logic [NUM_CORES-1:0]      core_debugack;

    // slave: the sequencer itself; master: host bridge plus core monitors
    modport slave (
        input  cmd_valid, cmd_op, cmd_core, cmd_addr, cmd_wdata, rsp_ready,
               core_rdata, core_ready, core_error, core_debugack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
               core_req, core_we, core_addr, core_wdata,
               core_break_req, core_resume_req
    );

    modport master (
        output cmd_valid, cmd_op, cmd_core, cmd_addr, cmd_wdata, rsp_ready,
               core_rdata, core_ready, core_error, core_debugack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
               core_req, core_we, core_addr, core_wdata,
               core_break_req, core_resume_req
    );
endinterface
`default_nettype wire

// File: rtl/multicore_debug_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicore_debug_sequencer
// Purpose  : Sequences single-core OCI accesses and broadcast halt/resume
//            against per-core debug monitors, one command at a time.
// Revision : 1.0 - initial release
// ============================================================================
module multicore_debug_sequencer #(
    parameter int NUM_CORES      = 8,
    parameter int CORE_ID_W      = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    multicore_debug_sequencer_if.slave  bus
);

    localparam int                   CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] C_OP_READ   = 2'b00;
    localparam logic [1:0] C_OP_WRITE  = 2'b01;
    localparam logic [1:0] C_OP_HALT   = 2'b10;
    localparam logic [1:0] C_OP_RESUME = 2'b11;

    localparam logic [1:0] C_ST_OK       = 2'b00;
    localparam logic [1:0] C_ST_MON_ERR  = 2'b01;
    localparam logic [1:0] C_ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] C_ST_BAD_CORE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ISSUE       = 3'd1,
        S_WAIT        = 3'd2,
        S_HALT_WAIT   = 3'd3,
        S_RESUME_WAIT = 3'd4,
        S_RESP        = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CORE_ID_W-1:0]   core_q, core_d;
    logic                   we_q, we_d;
    logic [7:0]             addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             status_q, status_d;
    logic                   cmd_ready_q, cmd_ready_d;

    logic                   w_accept;
    logic                   w_core_ok;
    logic                   w_last;
    logic                   w_all_ack;
    logic                   w_no_ack;
    logic                   w_sel_ready;
    logic                   w_sel_error;
    logic [31:0]            w_sel_rdata;
    logic [NUM_CORES-1:0]   w_req;
    logic                   w_access;

    assign w_accept  = bus.cmd_valid & cmd_ready_q;
    assign w_core_ok = 32'(bus.cmd_core) < 32'(NUM_CORES);
    assign w_last    = (cnt_q == C_CNT_LAST);
    assign w_all_ack = &bus.core_debugack;
    assign w_no_ack  = ~|bus.core_debugack;
    assign w_access  = (state_q == S_ISSUE) || (state_q == S_WAIT);

    // Per-core selection of the latched target's monitor signals
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_error = 1'b0;
        w_sel_rdata = '0;
        w_req       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_q == CORE_ID_W'(i)) begin
                w_sel_ready = bus.core_ready[i];
                w_sel_error = bus.core_error[i];
                w_sel_rdata = bus.core_rdata[32*i +: 32];
                w_req[i]    = (state_q == S_ISSUE);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        core_d   = core_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    core_d  = bus.cmd_core;
                    we_d    = (bus.cmd_op == C_OP_WRITE);
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    cnt_d   = '0;
                    case (bus.cmd_op)
                        C_OP_READ, C_OP_WRITE: begin
                            if (w_core_ok) begin
                                state_d = S_ISSUE;
                            end else begin
                                state_d  = S_RESP;
                                status_d = C_ST_BAD_CORE;
                                rdata_d  = '0;
                            end
                        end
                        C_OP_HALT:   state_d = S_HALT_WAIT;
                        C_OP_RESUME: state_d = S_RESUME_WAIT;
                        default:     state_d = S_IDLE;
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A ready seen on the final allowed cycle still completes normally
                if (w_sel_ready) begin
                    state_d  = S_RESP;
                    rdata_d  = we_q ? 32'h0 : w_sel_rdata;
                    status_d = w_sel_error ? C_ST_MON_ERR : C_ST_OK;
                end else if (w_last) begin
                    state_d  = S_RESP;
                    rdata_d  = '0;
                    status_d = C_ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALT_WAIT, S_RESUME_WAIT: begin
                if (((state_q == S_HALT_WAIT) && w_all_ack) ||
                    ((state_q == S_RESUME_WAIT) && w_no_ack)) begin
                    state_d  = S_RESP;
                    rdata_d  = 32'(bus.core_debugack);
                    status_d = C_ST_OK;
                end else if (w_last) begin
                    state_d  = S_RESP;
                    rdata_d  = 32'(bus.core_debugack);
                    status_d = C_ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered so it reads 0 throughout reset and rises one cycle after
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            core_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            status_q    <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            core_q      <= core_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    always_comb begin
        bus.cmd_ready       = cmd_ready_q;
        bus.rsp_valid       = (state_q == S_RESP);
        bus.rsp_rdata       = rdata_q;
        bus.rsp_status      = status_q;
        bus.core_req        = w_req;
        bus.core_we         = w_access & we_q;
        bus.core_addr       = w_access ? addr_q  : 8'h0;
        bus.core_wdata      = w_access ? wdata_q : 32'h0;
        bus.core_break_req  = {NUM_CORES{state_q == S_HALT_WAIT}};
        bus.core_resume_req = {NUM_CORES{state_q == S_RESUME_WAIT}};
    end

endmodule
`default_nettype wire

// File: tb/tb_multicore_debug_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicore_debug_sequencer
// Purpose  : Directed and randomized bench for the multicore debug sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicore_debug_sequencer;

    localparam int NC   = 8;
    localparam int CW   = 3;
    localparam int TO   = 16;
    localparam int NC_B = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   sched [8];

    always #5 clk = ~clk;

    multicore_debug_sequencer_if #(.NUM_CORES(NC),   .CORE_ID_W(CW)) bus ();
    multicore_debug_sequencer_if #(.NUM_CORES(NC_B), .CORE_ID_W(CW)) bus_b ();

    multicore_debug_sequencer #(.NUM_CORES(NC), .CORE_ID_W(CW), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multicore_debug_sequencer #(.NUM_CORES(NC_B), .CORE_ID_W(CW), .TIMEOUT_CYCLES(TO)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic noise();
        for (int i = 0; i < NC; i++) begin
            bus.core_rdata[32*i +: 32] = $urandom;
        end
        bus.core_ready    = NC'($urandom);
        bus.core_error    = NC'($urandom);
        bus.core_debugack = NC'($urandom);
    endtask

    // Target core gets the given ready/error/rdata; all other cores are random
    task automatic drive_cores(input int tgt, input bit rdy, input bit err, input logic [31:0] rd);
        for (int i = 0; i < NC; i++) begin
            bus.core_rdata[32*i +: 32] = $urandom;
        end
        bus.core_ready       = NC'($urandom);
        bus.core_error       = NC'($urandom);
        bus.core_ready[tgt]  = rdy;
        if (rdy) begin
            bus.core_error[tgt]          = err;
            bus.core_rdata[32*tgt +: 32] = rd;
        end
    endtask

    function automatic logic [NC-1:0] ack_at(input bit halt, input int k);
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) begin
            v[i] = halt ? (k >= sched[i]) : (k < sched[i]);
        end
        return v;
    endfunction

    task automatic start_cmd(input logic [1:0] op, input int core, input logic [7:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk("accept_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_core  = CW'(core);
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_core  = CW'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = $urandom;
    endtask

    task automatic resp_phase(input string tag, input logic [31:0] exp_rd, input logic [1:0] exp_st, input int stall);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            chk({tag, "_valid"},   bus.rsp_valid, 1);
            chk({tag, "_rdata"},   bus.rsp_rdata, exp_rd);
            chk({tag, "_status"},  bus.rsp_status, exp_st);
            chk({tag, "_strobes"}, {bus.core_req, bus.core_we, bus.core_break_req, bus.core_resume_req}, 0);
            noise();
            bus.rsp_ready = (s == stall);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_done"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    // dly = index of the WAIT cycle in which the target raises ready (>= TO: never)
    task automatic access(input bit wr, input int core, input logic [7:0] addr, input logic [31:0] wd,
                          input int dly, input bit err, input logic [31:0] rd, input int stall);
        int          n_wait;
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        if (dly < TO) begin
            n_wait = dly + 1;
            exp_st = err ? 2'b01 : 2'b00;
            exp_rd = wr ? 32'h0 : rd;
        end else begin
            n_wait = TO;
            exp_st = 2'b10;
            exp_rd = 32'h0;
        end
        drive_cores(core, 1'b0, 1'b0, 32'h0);
        start_cmd(wr ? 2'b01 : 2'b00, core, addr, wd);
        chk("issue_req",   bus.core_req, NC'(1) << core);
        chk("issue_bus",   {bus.core_we, bus.core_addr, bus.core_wdata}, {wr, addr, wd});
        chk("issue_ready", {bus.cmd_ready, bus.rsp_valid}, 0);
        drive_cores(core, 1'b1, !err, $urandom);
        for (int k = 0; k < n_wait; k++) begin
            @(negedge clk);
            chk("wait_req",  bus.core_req, 0);
            chk("wait_bus",  {bus.core_we, bus.core_addr, bus.core_wdata}, {wr, addr, wd});
            chk("wait_rsp",  bus.rsp_valid, 0);
            drive_cores(core, k == dly, err, rd);
        end
        @(negedge clk);
        resp_phase("acc", exp_rd, exp_st, stall);
    endtask

    task automatic bcast(input bit halt, input int stall);
        int            k_exit;
        logic [1:0]    exp_st;
        logic [NC-1:0] v;
        k_exit = TO - 1;
        exp_st = 2'b10;
        for (int k = TO - 1; k >= 0; k--) begin
            v = ack_at(halt, k);
            if (halt ? (&v) : (v == '0)) begin
                k_exit = k;
                exp_st = 2'b00;
            end
        end
        start_cmd(halt ? 2'b10 : 2'b11, $urandom_range(0, NC - 1), 8'($urandom), $urandom);
        for (int k = 0; k <= k_exit; k++) begin
            if (k > 0) @(negedge clk);
            chk("bc_break",  bus.core_break_req,  halt ? {NC{1'b1}} : '0);
            chk("bc_resume", bus.core_resume_req, halt ? '0 : {NC{1'b1}});
            chk("bc_idle",   {bus.rsp_valid, bus.core_req, bus.cmd_ready}, 0);
            bus.core_debugack = ack_at(halt, k);
        end
        @(negedge clk);
        resp_phase("bc", 32'(ack_at(halt, k_exit)), exp_st, stall);
    endtask

    task automatic bad_core_b(input logic [1:0] op, input int core);
        @(negedge clk);
        chk("b_ready", bus_b.cmd_ready, 1);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_op    = op;
        bus_b.cmd_core  = CW'(core);
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        chk("b_bad_rsp", {bus_b.rsp_valid, bus_b.rsp_status, bus_b.core_req}, {1'b1, 2'b11, 6'h00});
        chk("b_bad_rdata", bus_b.rsp_rdata, 0);
        bus_b.rsp_ready = 1'b1;
        @(negedge clk);
        bus_b.rsp_ready = 1'b0;
        chk("b_bad_done", {bus_b.rsp_valid, bus_b.cmd_ready, bus_b.core_req}, {1'b0, 1'b1, 6'h00});
    endtask

    initial begin
        int sel;
        int dly;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_core = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
        bus.rsp_ready = 0; bus.core_rdata = '0; bus.core_ready = '0; bus.core_error = '0;
        bus.core_debugack = '0;
        bus_b.cmd_valid = 0; bus_b.cmd_op = 0; bus_b.cmd_core = 0; bus_b.cmd_addr = 0;
        bus_b.cmd_wdata = 0; bus_b.rsp_ready = 0; bus_b.core_rdata = '0; bus_b.core_ready = '0;
        bus_b.core_error = '0; bus_b.core_debugack = '0;

        repeat (3) @(negedge clk);
        chk("rst_ctl",  {bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.core_req, bus.core_we,
                         bus.core_addr, bus.core_break_req, bus.core_resume_req}, 0);
        chk("rst_data", {bus.rsp_rdata, bus.core_wdata}, 0);
        chk("rst_b",    {bus_b.cmd_ready, bus_b.rsp_valid, bus_b.core_req, bus_b.core_break_req}, 0);
        reset = 1'b0;

        // Directed accesses
        access(1'b0, 5, 8'h12, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0);
        access(1'b1, 0, 8'h34, 32'h0000A5A5, 0, 1'b0, 32'h12345678, 1);
        access(1'b0, 2, 8'h56, 32'h0, 1000, 1'b0, 32'h0BADF00D, 0);
        access(1'b0, 2, 8'h57, 32'h0, TO - 1, 1'b0, 32'h76543210, 0);
        access(1'b0, 3, 8'h58, 32'h0, 2, 1'b1, 32'hFEEDFACE, 2);

        // Halt with staggered acks, last at cycle 9; resume stuck on core 3
        for (int i = 0; i < NC; i++) sched[i] = $urandom_range(0, 8);
        sched[6] = 9;
        bcast(1'b1, 1);
        for (int i = 0; i < NC; i++) sched[i] = $urandom_range(0, 5);
        sched[3] = 1000;
        bcast(1'b0, 0);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NC; i++) sched[i] = $urandom_range(0, 20);
            bcast(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        for (int n = 0; n < 12; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      dly = $urandom_range(0, 6);
            else if (sel < 8) dly = TO - 1;
            else              dly = $urandom_range(TO, TO + 20);
            access(1'($urandom_range(0, 1)), $urandom_range(0, NC - 1), 8'($urandom), $urandom,
                   dly, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
        end

        // Stalled response, then reset during RESP
        drive_cores(1, 1'b0, 1'b0, 32'h0);
        start_cmd(2'b00, 1, 8'h40, 32'h0);
        drive_cores(1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive_cores(1, 1'b1, 1'b0, 32'hCAFE0001);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            chk("stall_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_rdata}, {1'b1, 2'b00, 32'hCAFE0001});
            noise();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rstr_ctl",  {bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.core_req, bus.core_we,
                          bus.core_addr, bus.core_break_req, bus.core_resume_req}, 0);
        chk("rstr_data", {bus.rsp_rdata, bus.core_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstr_rel", {bus.cmd_ready, bus.rsp_valid}, 2'b10);

        // Reset during WAIT
        drive_cores(4, 1'b0, 1'b0, 32'h0);
        start_cmd(2'b01, 4, 8'h55, 32'h11112222);
        drive_cores(4, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive_cores(4, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstw_pre", {bus.core_we, bus.core_addr}, {1'b1, 8'h55});
        reset = 1'b1;
        drive_cores(4, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("rstw_ctl",  {bus.cmd_ready, bus.rsp_valid, bus.core_req, bus.core_we, bus.core_addr}, 0);
        chk("rstw_data", {bus.rsp_rdata, bus.core_wdata}, 0);
        reset = 1'b0;
        bus.core_ready = '0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("rstw_after", {bus.cmd_ready, bus.rsp_valid, bus.core_we, bus.core_req}, {1'b1, 1'b0, 1'b0, 8'h00});
        end

        // Six-core instance: out-of-range cores rejected, in-range core issued
        bad_core_b(2'b00, 7);
        bad_core_b(2'b01, 6);
        @(negedge clk);
        bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 2'b00; bus_b.cmd_core = 3'd5;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        chk("b_issue", {bus_b.core_req, bus_b.rsp_valid}, {6'h20, 1'b0});
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("b_wait", {bus_b.rsp_valid, bus_b.core_req}, 0);
        end
        @(negedge clk);
        chk("b_timeout", {bus_b.rsp_valid, bus_b.rsp_status, bus_b.rsp_rdata}, {1'b1, 2'b10, 32'h0});
        bus_b.rsp_ready = 1'b1;
        @(negedge clk);
        bus_b.rsp_ready = 1'b0;
        chk("b_done", {bus_b.rsp_valid, bus_b.cmd_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
